// File: rtl/nios_security_led_pio_pkg.sv
// Shared constants for the LED PIO: register map, STATUS bit positions
// and the blink phase state encoding.
package nios_security_led_pio_pkg;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
   localparam logic [2:0] ADDR_PERIOD   = 3'd2;
   localparam logic [2:0] ADDR_STATUS   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET   = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
   localparam logic [2:0] ADDR_TOGGLE   = 3'd6;

   localparam int STATUS_PHASE_BIT = 0;
   localparam int STATUS_RUN_BIT   = 1;

   typedef enum logic {
      PH_LO = 1'b0,
      PH_HI = 1'b1
   } phase_e;

endpackage

// File: rtl/nios_security_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED PIO (zero wait-state, write-only
// strobe plus combinational read data).
interface nios_security_led_pio_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/nios_security_blink_timer.sv
// Blink half-period timer: free-running counter 0..period-1 that flips the
// phase on every wrap. Stopped (counter and phase held at 0) while period
// is zero; any period write restarts it from counter 0, phase low.
module nios_security_blink_timer
   import nios_security_led_pio_pkg::*;
#(
   parameter int PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PERIOD_W-1:0] period,
   input  logic                period_wr,
   output logic                phase
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   phase_e              state_q, state_d;
   logic                wrap;

   // Only meaningful when period is nonzero; the zero case is handled first below.
   assign wrap = (cnt_q == (period - PERIOD_W'(1)));

   // Counter and phase state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         state_q <= PH_LO;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   // Next counter/phase: a period write beats the wrap, zero period parks the timer.
   always_comb begin
      cnt_d   = cnt_q + PERIOD_W'(1);
      state_d = state_q;
      if (period_wr || (period == '0)) begin
         cnt_d   = '0;
         state_d = PH_LO;
      end else if (wrap) begin
         cnt_d   = '0;
         state_d = (state_q == PH_LO) ? PH_HI : PH_LO;
      end
   end

   assign phase = (state_q == PH_HI);

endmodule

// File: rtl/nios_security_led_pio.sv
// Avalon-MM output PIO with atomic set/clear/toggle strobes and a hardware
// blink engine. Bits enabled in BLINK_EN are XORed with the blink phase and
// the result is registered onto out_port.
module nios_security_led_pio
   import nios_security_led_pio_pkg::*;
#(
   parameter int          WIDTH        = 32,
   parameter int          PERIOD_W     = 24,
   parameter logic [31:0] RESET_VALUE  = 32'h0,
   // Truncated to PERIOD_W bits; pick PERIOD_W wide enough for the value.
   parameter int unsigned RESET_PERIOD = 25000000
) (
   input  logic                      clk,
   input  logic                      reset,
   nios_security_led_pio_if.slave    bus,
   output logic [WIDTH-1:0]          out_port
);

   localparam logic [PERIOD_W-1:0] RST_PERIOD = PERIOD_W'(RESET_PERIOD);
   localparam logic [WIDTH-1:0]    RST_DATA   = RESET_VALUE[WIDTH-1:0];

   logic [WIDTH-1:0]    data_q;
   logic [WIDTH-1:0]    blink_q;
   logic [PERIOD_W-1:0] period_q;
   logic [WIDTH-1:0]    out_q;
   logic [WIDTH-1:0]    wd;
   logic                wr;
   logic                period_wr;
   logic                phase;
   logic                running;
   logic [31:0]         rd;

   assign wr        = bus.chipselect && !bus.write_n;
   assign wd        = bus.writedata[WIDTH-1:0];
   assign period_wr = wr && (bus.address == ADDR_PERIOD);
   assign running   = (period_q != '0) && (blink_q != '0);

   nios_security_blink_timer #(
      .PERIOD_W (PERIOD_W)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .period    (period_q),
      .period_wr (period_wr),
      .phase     (phase)
   );

   // Register file writes and the registered output; reset overrides any write.
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q   <= RST_DATA;
         blink_q  <= '0;
         period_q <= RST_PERIOD;
         out_q    <= RST_DATA;
      end else begin
         out_q <= data_q ^ (blink_q & {WIDTH{phase}});
         if (wr) begin
            case (bus.address)
               ADDR_DATA:     data_q   <= wd;
               ADDR_BLINK_EN: blink_q  <= wd;
               ADDR_PERIOD:   period_q <= bus.writedata[PERIOD_W-1:0];
               ADDR_OUTSET:   data_q   <= data_q | wd;
               ADDR_OUTCLEAR: data_q   <= data_q & ~wd;
               ADDR_TOGGLE:   data_q   <= data_q ^ wd;
               default:       ;
            endcase
         end
      end
   end

   // Zero-latency read mux; strobe and reserved addresses read as zero.
   always_comb begin
      rd = '0;
      case (bus.address)
         ADDR_DATA:     rd[WIDTH-1:0]    = data_q;
         ADDR_BLINK_EN: rd[WIDTH-1:0]    = blink_q;
         ADDR_PERIOD:   rd[PERIOD_W-1:0] = period_q;
         ADDR_STATUS: begin
            rd[STATUS_PHASE_BIT] = phase;
            rd[STATUS_RUN_BIT]   = running;
         end
         default:       ;
      endcase
   end

   assign bus.readdata = rd;
   assign out_port     = out_q;

endmodule

// File: tb/tb_nios_security_led_pio.sv
// Scoreboard bench for the LED PIO: stimulus pushes expected read/out_port
// values, a negedge monitor pops and compares whenever a probe is raised.
module tb_nios_security_led_pio;
   import nios_security_led_pio_pkg::*;

   localparam int          WIDTH    = 8;
   localparam int          PERIOD_W = 25;
   localparam logic [31:0] RV       = 32'h5;
   localparam int unsigned RP       = 25000000;

   logic             clk = 1'b0;
   logic             reset;
   logic [WIDTH-1:0] out_port;

   nios_security_led_pio_if bus_if ();

   nios_security_led_pio #(
      .WIDTH        (WIDTH),
      .PERIOD_W     (PERIOD_W),
      .RESET_VALUE  (RV),
      .RESET_PERIOD (RP)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if.slave),
      .out_port (out_port)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      bit          is_port;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb[$];
   bit          probe = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;
   exp_t        mon_e;
   logic [31:0] mon_act;

   // Monitor: compare the DUT output against the oldest expectation.
   always @(negedge clk) begin
      if (probe) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: probe raised with no expected value");
         end else begin
            mon_e   = sb.pop_front();
            mon_act = mon_e.is_port ? {24'b0, out_port} : bus_if.readdata;
            if (mon_act !== mon_e.exp) begin
               n_fail++;
               $display("FAIL %s: got 0x%0h expected 0x%0h", mon_e.name, mon_act, mon_e.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      bus_if.address    = a;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      bus_if.writedata  = d;
      cyc();
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
      exp_t e;
      e.name = nm; e.is_port = 1'b0; e.exp = exp;
      bus_if.address    = a;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b1;
      sb.push_back(e);
      probe = 1'b1;
      cyc();
      probe = 1'b0;
      bus_if.chipselect = 1'b0;
   endtask

   task automatic pchk(input logic [WIDTH-1:0] exp, input string nm);
      exp_t e;
      e.name = nm; e.is_port = 1'b1; e.exp = {24'b0, exp};
      sb.push_back(e);
      probe = 1'b1;
      cyc();
      probe = 1'b0;
   endtask

   logic [12:0] blink_tbl;
   logic [7:0]  wrap_tbl;

   initial begin
      // out_port samples, one per clock, LSB first
      blink_tbl = 13'h01E0;   // 0,0,0,0,0,1,1,1,1,0,0,0,0
      wrap_tbl  = 8'h70;      // 0,0,0,0,1,1,1,0

      reset             = 1'b1;
      bus_if.address    = '0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = '0;
      cyc();
      cyc();
      reset = 1'b0;

      // reset state
      pchk(8'h05, "reset_out_port");
      rd(ADDR_DATA, 32'h5, "reset_data");
      rd(ADDR_PERIOD, 32'd25000000, "reset_period");
      rd(ADDR_BLINK_EN, 32'h0, "reset_blink_en");
      rd(ADDR_STATUS, 32'h0, "reset_status");
      rd(3'd7, 32'h0, "reserved_read");

      // atomic strobes: F0 -> FF -> CF -> 4E
      wr(ADDR_DATA, 32'hF0);
      wr(ADDR_OUTSET, 32'h0F);
      wr(ADDR_OUTCLEAR, 32'h30);
      wr(ADDR_TOGGLE, 32'h81);
      pchk(8'hCF, "out_port_lag");
      pchk(8'h4E, "out_port_atomic");
      rd(ADDR_DATA, 32'h4E, "data_atomic");
      wr(ADDR_OUTSET, 32'hFFFF_FF00);
      wr(3'd7, 32'hFF);
      rd(ADDR_DATA, 32'h4E, "data_upper_ignored");
      rd(ADDR_OUTSET, 32'h0, "outset_reads_zero");

      // blink with half-period 4
      wr(ADDR_DATA, 32'h0);
      wr(ADDR_BLINK_EN, 32'h1);
      wr(ADDR_PERIOD, 32'd4);
      for (int k = 0; k < 13; k++) pchk({7'b0, blink_tbl[k]}, $sformatf("blink4_%0d", k));
      rd(ADDR_STATUS, 32'h3, "status_running");
      wr(ADDR_PERIOD, 32'd0);
      rd(ADDR_STATUS, 32'h0, "status_stopped");
      pchk(8'h00, "stop_out_data");
      pchk(8'h00, "stop_out_hold");
      rd(ADDR_PERIOD, 32'h0, "period_zero");

      // period rewrite on the wrap cycle restarts the timer
      wr(ADDR_PERIOD, 32'd3);
      cyc();
      cyc();
      wr(ADDR_PERIOD, 32'd3);
      for (int k = 0; k < 8; k++) pchk({7'b0, wrap_tbl[k]}, $sformatf("wrap3_%0d", k));

      // reset mid-blink with a competing DATA write
      reset             = 1'b1;
      bus_if.address    = ADDR_DATA;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      bus_if.writedata  = 32'hFF;
      cyc();
      reset             = 1'b0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      pchk(8'h05, "rst_out_port");
      rd(ADDR_DATA, 32'h5, "rst_data");
      rd(ADDR_BLINK_EN, 32'h0, "rst_blink_en");
      rd(ADDR_PERIOD, 32'd25000000, "rst_period");
      rd(ADDR_STATUS, 32'h0, "rst_status");
      pchk(8'h05, "rst_out_hold");

      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
